sr_hypo_seq: RTL and testbench
==============================

Name: sr_hypo_seq

Overview:
Multi-cycle sequencer for the HYPO custom instruction: result = floor(sqrt(a*a + b*b)). It does not use a private multiplier or square-root unit. It borrows the core's shared sr_alu through the aluSrc=2'b10 path, driving oper/srcA/srcB and reading aluResult back each cycle. It sits beside sr_control: multiCycleExt is its start, and its busy output stalls pcWe until the result is ready for wdSrc=2'b10 write-back.

Parameters:
IN_W, 8, operand width. Squares use 2*IN_W+1 bits, result uses IN_W+1 bits. IN_W must be ≤ 15.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level request (multiCycleExt); held high while the HYPO instruction is current
a  input  IN_W  operand A (rd1 low bits), sampled at accept
b  input  IN_W  operand B (rd2 low bits), sampled at accept
aluResult  input  32  shared ALU result, combinational same cycle
aluOper  output  3  ALU operation (`ALU_ADD/`ALU_SUB/`ALU_SLTU codes)
aluSrcA  output  32  ALU operand A
aluSrcB  output  32  ALU operand B
result  output  IN_W+1  hypotenuse, registered
busy  output  1  stall request to the core

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all internal registers cleared; result=0; busy=0. Reset mid-operation aborts with no completion.
- aluOper, aluSrcA and aluSrcB are combinational from state and registers. In IDLE and DONE they drive ADD, 0, 0.
- busy = (state ∉ {IDLE, DONE}) | (state==IDLE & start). busy is high combinationally in the accept cycle, so the PC holds from the first cycle.
- IDLE:
  - If start: latch a and b; clear acc, sqa and sqb; set i=0; go to SQA.
- SQA, IN_W cycles (i = 0..IN_W-1):
  - oper=ADD, srcA=acc, srcB = a[i] ? (a<<i) : 0.
  - acc<=aluResult.
  - After the last cycle: sqa<=aluResult; acc<=0; go to SQB.
  - A cycle is spent even when the bit is 0, giving fixed latency.
- SQB: same as SQA with b, writing sqb.
- SUM, 1 cycle: oper=ADD, srcA=sqa, srcB=sqb. op<=aluResult; res<=0; one<=1<<(2*IN_W); go to R_ADD.
- Integer square root, IN_W+1 iterations of 3 cycles each:
  - R_ADD: oper=ADD, srcA=res, srcB=one; t<=aluResult.
  - R_CMP: oper=SLTU, srcA=op, srcB=t; lt<=aluResult[0].
  - R_SUB: oper=SUB, srcA=op, srcB=t.
    - If !lt: op<=aluResult; res<=(res>>1)|one.
    - Else: res<=res>>1.
    - Always: one<=one>>2.
    - If one==1 in this cycle: go to DONE; else go to R_ADD.
- DONE, 1 cycle:
  - result<=final res[IN_W:0], visible this cycle.
  - busy=0, so the core writes the result and advances the PC at the next edge.
  - Go to IDLE unconditionally. DONE never re-accepts, even if start is still high from the same instruction.
- Back-to-back HYPO: start is high in IDLE, which is a new accept.
- Latency: DONE is entered 5*IN_W+5 rising edges after the accept edge (45 for IN_W=8). The instruction occupies 46 cycles.
- start low in any busy state other than IDLE: abort to IDLE at the next edge. result is unchanged and DONE does not occur.
- Width: all ALU operands are zero-extended to 32 bits. The maximum sum is 2*(2^IN_W-1)^2, so no overflow occurs. result holds its value until the next DONE.

Test Plan:
- a=3, b=4, start held → busy high from accept cycle; DONE 45 edges after accept; result=5; busy low exactly 1 cycle.
- a=255, b=255 → sum 130050; result=360.
- a=0, b=0 → result=0. a=1, b=0 → result=1. a=7, b=1 → result=7 (floor of sqrt 50).
- Two HYPO back-to-back, (5,12) then (8,15), start continuously high → results 13 then 17; second accept in the IDLE cycle after DONE; no spurious accept in DONE.
- rst_n pulsed low mid-SQRT → immediate IDLE, busy=0, result=0. Next start with (6,8) → 10.
- start dropped during SQB → IDLE next edge, prior result retained, no DONE cycle. ALU port check in every state: oper/srcA/srcB match the sequence above (e.g. R_CMP drives SLTU with op and t).

Source files
------------

// File: rtl/sr_hypo_seq.sv
// -----------------------------------------------------------------------------
// sr_hypo_seq
// Multi-cycle sequencer for the HYPO custom instruction:
//     result = floor(sqrt(a*a + b*b))
// There is no private multiplier or root unit. Every arithmetic step is pushed
// through the core's shared ALU (aluSrc path 2'b10): this block drives
// aluOper/aluSrcA/aluSrcB and consumes aluResult in the same cycle.
//
// Phases:
//   SQA / SQB : shift-and-add squaring, one operand bit per cycle (fixed latency)
//   SUM       : sqa + sqb
//   R_ADD/R_CMP/R_SUB : restoring integer square root, one result bit per
//               three cycles, IN_W+1 iterations
//   DONE      : result is valid, busy drops so the core writes it back
//
// Ports:
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   start      level request (multiCycleExt), high while HYPO is current
//   a, b       operands, sampled in the accept cycle
//   aluResult  shared ALU result (combinational, same cycle)
//   aluOper    ALU operation code
//   aluSrcA    ALU operand A (zero-extended)
//   aluSrcB    ALU operand B (zero-extended)
//   result     hypotenuse, registered, holds until the next completion
//   busy       stall request to the core (holds pcWe low)
//
// IN_W must not exceed 15 so that squares (2*IN_W+1 bits) fit the 32-bit ALU
// and the bit counter fits in 4 bits.
// -----------------------------------------------------------------------------

`ifndef ALU_ADD
`define ALU_ADD  3'b000
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 3'b011
`endif
`ifndef ALU_SUB
`define ALU_SUB  3'b100
`endif

module sr_hypo_seq #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    input  logic [31:0]     aluResult,
    output logic [2:0]      aluOper,
    output logic [31:0]     aluSrcA,
    output logic [31:0]     aluSrcB,
    output logic [IN_W:0]   result,
    output logic            busy
);

    localparam int SQ_W = 2 * IN_W + 1;

    localparam logic [2:0] OP_ADD  = `ALU_ADD;
    localparam logic [2:0] OP_SUB  = `ALU_SUB;
    localparam logic [2:0] OP_SLTU = `ALU_SLTU;

    localparam logic [3:0]      LAST_I   = 4'(IN_W - 1);
    // Highest power of four that can still be below the largest sum.
    localparam logic [SQ_W-1:0] ONE_INIT = {1'b1, {(2 * IN_W){1'b0}}};
    localparam logic [SQ_W-1:0] ONE_LAST = {{(SQ_W - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQA   = 3'd1,
        S_SQB   = 3'd2,
        S_SUM   = 3'd3,
        S_RADD  = 3'd4,
        S_RCMP  = 3'd5,
        S_RSUB  = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    // Zero-extend an internal datapath word onto the 32-bit ALU bus.
    function automatic logic [31:0] zext_sq(input logic [SQ_W-1:0] v);
        logic [31:0] w;
        w            = 32'd0;
        w[SQ_W-1:0]  = v;
        return w;
    endfunction

    // Partial product for squaring: x<<sh when bit sh of x is set, else 0.
    function automatic logic [31:0] partial_term(input logic [IN_W-1:0] x,
                                                 input logic [3:0]      sh);
        logic [SQ_W-1:0] ext;
        logic [SQ_W-1:0] shr;
        logic [31:0]     term;
        ext           = '0;
        ext[IN_W-1:0] = x;
        shr           = ext >> sh;
        if (shr[0]) begin
            term = zext_sq(ext << sh);
        end else begin
            term = 32'd0;
        end
        return term;
    endfunction

    state_e          state_q, state_d;
    logic [IN_W-1:0] a_q, a_d;
    logic [IN_W-1:0] b_q, b_d;
    logic [3:0]      i_q, i_d;
    logic [SQ_W-1:0] acc_q, acc_d;
    logic [SQ_W-1:0] sqa_q, sqa_d;
    logic [SQ_W-1:0] sqb_q, sqb_d;
    logic [SQ_W-1:0] op_q, op_d;
    logic [SQ_W-1:0] res_q, res_d;
    logic [SQ_W-1:0] one_q, one_d;
    logic [SQ_W-1:0] t_q, t_d;
    logic            lt_q, lt_d;
    logic [IN_W:0]   result_q, result_d;

    logic [2:0]      alu_oper_s;
    logic [31:0]     alu_a_s;
    logic [31:0]     alu_b_s;
    logic            busy_s;
    logic [SQ_W-1:0] res_next_s;
    logic [SQ_W-1:0] alu_lo_s;
    logic            unused_alu_hi_s;

    assign alu_lo_s        = aluResult[SQ_W-1:0];
    // Upper ALU bits are always zero for in-range operands.
    assign unused_alu_hi_s = ^aluResult[31:SQ_W];

    // Next-state, datapath update and ALU port decode.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        i_d        = i_q;
        acc_d      = acc_q;
        sqa_d      = sqa_q;
        sqb_d      = sqb_q;
        op_d       = op_q;
        res_d      = res_q;
        one_d      = one_q;
        t_d        = t_q;
        lt_d       = lt_q;
        result_d   = result_q;
        res_next_s = res_q;
        alu_oper_s = OP_ADD;
        alu_a_s    = 32'd0;
        alu_b_s    = 32'd0;
        busy_s     = 1'b1;

        case (state_q)
            S_IDLE: begin
                // Stall from the very first cycle of the instruction.
                busy_s = start;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    sqa_d   = '0;
                    sqb_d   = '0;
                    i_d     = 4'd0;
                    state_d = S_SQA;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_SQA: begin
                alu_oper_s = OP_ADD;
                alu_a_s    = zext_sq(acc_q);
                alu_b_s    = partial_term(a_q, i_q);
                acc_d      = alu_lo_s;
                if (i_q == LAST_I) begin
                    sqa_d   = alu_lo_s;
                    acc_d   = '0;
                    i_d     = 4'd0;
                    state_d = S_SQB;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = S_SQA;
                end
            end

            S_SQB: begin
                alu_oper_s = OP_ADD;
                alu_a_s    = zext_sq(acc_q);
                alu_b_s    = partial_term(b_q, i_q);
                acc_d      = alu_lo_s;
                if (i_q == LAST_I) begin
                    sqb_d   = alu_lo_s;
                    acc_d   = '0;
                    i_d     = 4'd0;
                    state_d = S_SUM;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = S_SQB;
                end
            end

            S_SUM: begin
                alu_oper_s = OP_ADD;
                alu_a_s    = zext_sq(sqa_q);
                alu_b_s    = zext_sq(sqb_q);
                op_d       = alu_lo_s;
                res_d      = '0;
                one_d      = ONE_INIT;
                state_d    = S_RADD;
            end

            S_RADD: begin
                alu_oper_s = OP_ADD;
                alu_a_s    = zext_sq(res_q);
                alu_b_s    = zext_sq(one_q);
                t_d        = alu_lo_s;
                state_d    = S_RCMP;
            end

            S_RCMP: begin
                alu_oper_s = OP_SLTU;
                alu_a_s    = zext_sq(op_q);
                alu_b_s    = zext_sq(t_q);
                lt_d       = aluResult[0];
                state_d    = S_RSUB;
            end

            S_RSUB: begin
                alu_oper_s = OP_SUB;
                alu_a_s    = zext_sq(op_q);
                alu_b_s    = zext_sq(t_q);
                // op >= res+one: take the subtraction and set this root bit.
                if (!lt_q) begin
                    op_d       = alu_lo_s;
                    res_next_s = (res_q >> 1) | one_q;
                end else begin
                    res_next_s = res_q >> 1;
                end
                res_d = res_next_s;
                one_d = one_q >> 2;
                if (one_q == ONE_LAST) begin
                    // Load now so the value is already visible in DONE.
                    result_d = res_next_s[IN_W:0];
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_RADD;
                end
            end

            S_DONE: begin
                // Never re-accept here: start is still high from this instruction.
                busy_s  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Instruction withdrawn while working: abandon without completing.
        if ((state_q != S_IDLE) && (state_q != S_DONE) && !start) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end else begin
            // Keep the next state decoded above.
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= 4'd0;
            acc_q    <= '0;
            sqa_q    <= '0;
            sqb_q    <= '0;
            op_q     <= '0;
            res_q    <= '0;
            one_q    <= '0;
            t_q      <= '0;
            lt_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            acc_q    <= acc_d;
            sqa_q    <= sqa_d;
            sqb_q    <= sqb_d;
            op_q     <= op_d;
            res_q    <= res_d;
            one_q    <= one_d;
            t_q      <= t_d;
            lt_q     <= lt_d;
            result_q <= result_d;
        end
    end

    assign aluOper = alu_oper_s;
    assign aluSrcA = alu_a_s;
    assign aluSrcB = alu_b_s;
    assign busy    = busy_s;
    assign result  = result_q;

endmodule

// File: tb/tb_sr_hypo_seq.sv
module tb_sr_hypo_seq;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SLTU = 3'b011;
    localparam logic [2:0] SUB  = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_s;
    logic [7:0]  b_s;
    logic [31:0] alu_res;
    logic [2:0]  alu_oper;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [8:0]  result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sr_hypo_seq #(.IN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a_s),
        .b         (b_s),
        .aluResult (alu_res),
        .aluOper   (alu_oper),
        .aluSrcA   (src_a),
        .aluSrcB   (src_b),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared core ALU.
    always_comb begin
        case (alu_oper)
            ADD:     alu_res = src_a + src_b;
            SUB:     alu_res = src_a - src_b;
            SLTU:    alu_res = {31'd0, (src_a < src_b)};
            default: alu_res = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_alu(input string tag, input logic [2:0] op,
                             input int unsigned sa, input int unsigned sb);
        check_eq({tag, "_oper"}, {29'd0, alu_oper}, {29'd0, op});
        check_eq({tag, "_srcA"}, src_a, sa);
        check_eq({tag, "_srcB"}, src_b, sb);
    endtask

    // One full HYPO instruction. Starts at the IDLE cycle, returns in DONE.
    task automatic do_hypo(input logic [7:0] av, input logic [7:0] bv,
                           input logic [8:0] expv, input bit keep);
        int unsigned acc, sqa, sqb, opv, res, one, t, term, xv;
        bit lt;
        int done_k;
        acc = 0; sqa = 0; sqb = 0; opv = 0; res = 0; one = 0; t = 0; lt = 1'b0;
        done_k = -1;
        @(negedge clk);
        a_s = av; b_s = bv; start = 1'b1;
        #1;
        check_eq("accept_busy", {31'd0, busy}, 32'd1);
        check_alu("idle", ADD, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                xv   = (k <= 8) ? int'(av) : int'(bv);
                term = ((xv >> ((k - 1) % 8)) & 1) != 0 ? (xv << ((k - 1) % 8)) : 0;
                check_alu("sq", ADD, acc, term);
                acc = acc + term;
                if (k == 8)  begin sqa = acc; acc = 0; end
                if (k == 16) begin sqb = acc; acc = 0; end
            end else if (k == 17) begin
                check_alu("sum", ADD, sqa, sqb);
                opv = sqa + sqb; res = 0; one = 32'h1_0000;
            end else if (k <= 44) begin
                case ((k - 18) % 3)
                    0: begin check_alu("r_add", ADD, res, one); t = res + one; end
                    1: begin check_alu("r_cmp", SLTU, opv, t); lt = (opv < t); end
                    default: begin
                        check_alu("r_sub", SUB, opv, t);
                        if (!lt) begin opv = opv - t; res = (res >> 1) + one; end
                        else res = res >> 1;
                        one = one >> 2;
                    end
                endcase
            end else begin
                check_alu("done", ADD, 0, 0);
            end
            if (k <= 44) check_eq("busy_run", {31'd0, busy}, 32'd1);
            if (!busy) begin done_k = k; break; end
        end
        check_eq("latency", done_k, 45);
        check_eq("result", {23'd0, result}, {23'd0, expv});
        if (!keep) start = 1'b0;
    endtask

    initial begin
        int busy_seen;
        int res_changed;
        rst_n = 1'b0; start = 1'b0; a_s = 8'd0; b_s = 8'd0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_result", {23'd0, result}, 32'd0);
        check_alu("rst", ADD, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_hypo(8'd3, 8'd4, 9'd5, 1'b0);
        @(negedge clk);
        check_eq("idle_after_done", {31'd0, busy}, 32'd0);
        check_eq("result_hold", {23'd0, result}, 32'd5);

        do_hypo(8'd255, 8'd255, 9'd360, 1'b0);
        do_hypo(8'd0, 8'd0, 9'd0, 1'b0);
        do_hypo(8'd1, 8'd0, 9'd1, 1'b0);
        do_hypo(8'd7, 8'd1, 9'd7, 1'b0);

        // Back-to-back with start held high throughout.
        do_hypo(8'd5, 8'd12, 9'd13, 1'b1);
        do_hypo(8'd8, 8'd15, 9'd17, 1'b0);

        // Asynchronous reset in the middle of the root phase.
        @(negedge clk);
        a_s = 8'd9; b_s = 8'd12; start = 1'b1;
        repeat (25) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; start = 1'b0;
        #1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_result", {23'd0, result}, 32'd0);
        check_alu("midrst", ADD, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        do_hypo(8'd6, 8'd8, 9'd10, 1'b0);

        // Drop start during SQB: abort, keep prior result, no DONE.
        @(negedge clk);
        a_s = 8'd7; b_s = 8'd1; start = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("sqb_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_result", {23'd0, result}, 32'd10);
        check_alu("abort_idle", ADD, 0, 0);
        busy_seen = 0; res_changed = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (result != 9'd10) res_changed++;
        end
        check_eq("abort_quiet_busy", busy_seen, 0);
        check_eq("abort_quiet_result", res_changed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
